uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 133 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that merges several byte-stream requesters onto one UART
// serializer. It grants whole messages and inserts a fixed idle gap between them.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int MAX_MSG_LEN = 72,
    parameter int GAP_CYCLES  = 234,
    parameter int STALL_MAX   = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   trunc_err,
    output logic                   stall_err,
    output logic [1:0]             err_src
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = $clog2(STALL_MAX + 1);
    localparam int GW = $clog2(GAP_CYCLES + 2);

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    state_t          state;
    logic [IW-1:0]   own;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   win;
    logic            found;
    logic [7:0]      byte_cnt;
    logic [SW-1:0]   stall_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            in_xfer;
    logic            own_valid;
    logic            own_last;
    logic            xfer_fire;
    logic            len_hit;
    logic            stall_hit;

    // Search starts just after the last owner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid[IW'((int'(ptr) + k) % NUM_REQ)]) begin
                found = 1'b1;
                win   = IW'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    assign in_xfer   = (state == XFER);
    assign own_valid = req_valid[own];
    assign own_last  = req_last[own];
    assign tx_valid  = in_xfer && own_valid;
    assign tx_data   = in_xfer ? req_data[8*own +: 8] : 8'h00;
    assign xfer_fire = tx_valid && tx_ready;
    assign len_hit   = (byte_cnt == 8'(MAX_MSG_LEN - 1));
    assign stall_hit = in_xfer && !own_valid && (stall_cnt == SW'(STALL_MAX - 1));

    always_comb begin
        req_ready      = '0;
        req_ready[own] = in_xfer && tx_ready && own_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            own       <= '0;
            ptr       <= IW'(NUM_REQ - 1);
            byte_cnt  <= '0;
            stall_cnt <= '0;
            gap_cnt   <= '0;
            busy      <= 1'b0;
            trunc_err <= 1'b0;
            stall_err <= 1'b0;
            err_src   <= '0;
        end else begin
            trunc_err <= 1'b0;
            stall_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= XFER;
                        grant     <= NUM_REQ'(1) << win;
                        own       <= win;
                        busy      <= 1'b1;
                        byte_cnt  <= '0;
                        stall_cnt <= '0;
                    end
                end
                XFER: begin
                    stall_cnt <= own_valid ? '0 : stall_cnt + 1'b1;
                    if (xfer_fire)
                        byte_cnt <= byte_cnt + 8'd1;
                    if ((xfer_fire && (own_last || len_hit)) || stall_hit) begin
                        ptr     <= own;
                        grant   <= '0;
                        gap_cnt <= '0;
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                        // A real last byte wins over the length limit.
                        if (stall_hit) begin
                            stall_err <= 1'b1;
                            err_src   <= 2'(own);
                        end else if (!own_last) begin
                            trunc_err <= 1'b1;
                            err_src   <= 2'(own);
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: byte sources feed per-requester queues,
// expected bytes/errors are queued up front and a monitor checks what comes out.
module tb_uart_tx_arbiter;
    localparam int NREQ = 3;
    localparam int GAPC = 234;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              tx_ready;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              trunc_err;
    logic              stall_err;
    logic [1:0]        err_src;

    uart_tx_arbiter #(.NUM_REQ(NREQ), .MAX_MSG_LEN(72), .GAP_CYCLES(GAPC), .STALL_MAX(4096)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready), .grant(grant), .busy(busy),
        .trunc_err(trunc_err), .stall_err(stall_err), .err_src(err_src)
    );

    always #5 clk = ~clk;

    logic [8:0] sq [NREQ][$];   // {last, data} per requester
    logic [9:0] exp_q[$];       // {src, data} in expected output order
    logic [2:0] err_q[$];       // {is_stall, src}
    int n_cmp = 0;
    int n_bad = 0;
    int xfers = 0;
    int gap_run = 0;
    int gap_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        sq[r].push_back({l, d});
        exp_q.push_back({2'(r), d});
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c = 0;
        while ((sq[0].size() + sq[1].size() + sq[2].size() + exp_q.size()) != 0 || busy) begin
            @(negedge clk);
            c++;
            if (c > budget) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: timeout after %0d cycles, %0d bytes outstanding", name, c, exp_q.size());
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    // Byte sources: present queue heads at negedge, pop what was accepted.
    initial begin
        logic [NREQ-1:0] fire;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (sq[i].size() > 0) begin
                    req_valid[i]        = 1'b1;
                    req_data[8*i +: 8]  = sq[i][0][7:0];
                    req_last[i]         = sq[i][0][8];
                end else begin
                    req_valid[i]        = 1'b0;
                    req_data[8*i +: 8]  = 8'h00;
                    req_last[i]         = 1'b0;
                end
            end
            #4;
            fire = req_ready;
            for (int i = 0; i < NREQ; i++)
                if (fire[i] && sq[i].size() > 0) void'(sq[i].pop_front());
        end
    end

    // Monitor: sampled one time unit before each rising edge.
    initial begin
        logic [9:0] e;
        logic [2:0] ee;
        forever begin
            @(negedge clk);
            #4;
            if (tx_valid && tx_ready) begin
                xfers++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL xfer_unexpected: got byte %0h, nothing expected", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_data", 32'(tx_data), 32'(e[7:0]));
                    chk("grant_owner", 32'(grant), 32'(3'b001 << e[9:8]));
                end
            end
            if (trunc_err || stall_err) begin
                if (err_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL err_unexpected: got trunc=%0b stall=%0b src=%0d", trunc_err, stall_err, err_src);
                end else begin
                    ee = err_q.pop_front();
                    chk("err_kind", {30'd0, stall_err, trunc_err}, {30'd0, ee[2], ~ee[2]});
                    chk("err_src", 32'(err_src), 32'(ee[1:0]));
                    if (stall_err) chk("stall_grant", 32'(grant), 32'd0);
                end
            end
            if (busy && grant == '0) begin
                gap_run++;
                if (tx_valid || req_ready != '0) gap_bad++;
            end else if (gap_run > 0) begin
                chk("gap_len", 32'(gap_run), 32'(GAPC));
                gap_run = 0;
            end
        end
    end

    initial begin
        logic [7:0]  pat6 [6];
        logic [15:0] rdy_pat;
        int          base;
        int          c;
        pat6     = '{8'h28, 8'h5C, 8'h5F, 8'h5F, 8'h2F, 8'h29};
        rdy_pat  = 16'b1001_1011_0100_1101;
        tx_ready = 1'b1;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_errs", {30'd0, trunc_err, stall_err}, 32'd0);
        chk("rst_err_src", 32'(err_src), 32'd0);

        // Three simultaneous 2-byte messages: round-robin from requester 0.
        for (int r = 0; r < NREQ; r++) begin
            push(r, 8'(16*r + 1), 1'b0);
            push(r, 8'(16*r + 2), 1'b1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle("rr_order", 2000);

        // Exactly MAX_MSG_LEN bytes with last on the final one: no truncation.
        for (int k = 0; k < 72; k++) push(1, pat6[k % 6], k == 71);
        wait_idle("len72", 1000);

        // 80 bytes, last only on byte 80: truncation after 72, rest re-granted.
        err_q.push_back({1'b0, 2'd2});
        for (int k = 0; k < 80; k++) push(2, 8'(8'h80 + k), k == 79);
        wait_idle("trunc80", 1500);
        chk("trunc_err_src_hold", 32'(err_src), 32'd2);

        // Requester 0 sends 3 bytes then stalls.
        err_q.push_back({1'b1, 2'd0});
        for (int k = 0; k < 3; k++) push(0, 8'(8'hA0 + k), 1'b0);
        wait_idle("stall", 6000);
        chk("stall_err_src_hold", 32'(err_src), 32'd0);

        // tx_ready toggling mid-message.
        for (int k = 0; k < 6; k++) push(0, 8'(8'hC0 + k), k == 5);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            tx_ready = rdy_pat[i];
        end
        @(negedge clk);
        tx_ready = 1'b1;
        wait_idle("rdy_toggle", 1000);

        // Reset during byte 5 of a message from requester 1.
        base = xfers;
        for (int k = 0; k < 10; k++) push(1, 8'(8'hE0 + k), k == 9);
        c = 0;
        while (xfers < base + 4 && c < 400) begin
            @(negedge clk);
            c++;
        end
        chk("pre_rst_xfers", 32'(xfers - base), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_tx_data", 32'(tx_data), 32'd0);
        sq[1].delete();
        exp_q.delete();
        push(0, 8'h5A, 1'b1);
        push(1, 8'hA5, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        c = 0;
        while (grant == '0 && c < 10) begin
            @(negedge clk);
            c++;
        end
        chk("post_rst_grant", 32'(grant), 32'b001);
        wait_idle("post_rst", 1500);

        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("err_q_drained", 32'(err_q.size()), 32'd0);
        chk("gap_quiet", 32'(gap_bad), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end
endmodule
